// File: rtl/odometro_hall_if.sv
// Bus around the hall-sensor odometer: raw sensor and trip clear in,
// half-precision distance, strobe, pulse count and busy flag out.
interface odometro_hall_if;
  logic        sensor;
  logic        clear;
  logic [15:0] desplazamientof;
  logic        nuevo;
  logic [31:0] pulsos;
  logic        busy;

  modport master (
    output sensor,
    output clear,
    input  desplazamientof,
    input  nuevo,
    input  pulsos,
    input  busy
  );

  modport slave (
    input  sensor,
    input  clear,
    output desplazamientof,
    output nuevo,
    output pulsos,
    output busy
  );
endinterface

// File: rtl/odometro_hall.sv
// Wheel odometer: conditions the hall sensor, accumulates distance in Q22.10
// metres and normalises it into an IEEE-754 half with a shift-per-cycle FSM.
module odometro_hall #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CIRC_Q10        = 2130
) (
  input logic           clock,
  input logic           reset,
  odometro_hall_if.slave bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} StateType;

  logic          sensorMeta;
  logic          sSync;
  logic          stable;
  logic          stablePrev;
  logic [CW-1:0] debCnt;
  logic          pulse;

  logic [31:0]   acc;
  logic [31:0]   pulsosReg;
  logic          accChanged;
  logic [32:0]   accSum;

  StateType      state, stateNext;
  logic [31:0]   sr, srNext;
  logic [4:0]    k, kNext;
  logic          pend, pendNext;
  logic [15:0]   resultado, resultadoNext;
  logic [15:0]   desp, despNext;
  logic          nuevoReg, nuevoNext;
  logic [31:0]   shifted;
  logic [4:0]    kInc;

  // Exponent is 30-k because the leading one ends up at bit 25 (2^15 m at k=0).
  function automatic logic [15:0] packHalf(input logic [31:0] v, input logic [4:0] sh);
    return {1'b0, 5'd30 - sh, v[24:15]};
  endfunction

  // Two-flop synchroniser feeding a debouncer that accepts a level only after
  // it has differed from the debounced value for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      sensorMeta <= 1'b0;
      sSync      <= 1'b0;
      stable     <= 1'b0;
      stablePrev <= 1'b0;
      debCnt     <= '0;
    end else begin
      sensorMeta <= bus.sensor;
      sSync      <= sensorMeta;
      stablePrev <= stable;
      if (sSync == stable) begin
        debCnt <= '0;
      end else if (debCnt == DEB_MAX) begin
        stable <= sSync;
        debCnt <= '0;
      end else begin
        debCnt <= debCnt + 1'b1;
      end
    end
  end

  assign pulse  = stable & ~stablePrev;
  assign accSum = {1'b0, acc} + 33'(CIRC_Q10);

  // Distance and pulse count saturate; clear beats a coincident pulse and
  // still flags a change so a fresh zero gets converted.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc        <= '0;
      pulsosReg  <= '0;
      accChanged <= 1'b0;
    end else begin
      accChanged <= 1'b0;
      if (bus.clear) begin
        acc        <= '0;
        pulsosReg  <= '0;
        accChanged <= 1'b1;
      end else if (pulse) begin
        acc        <= accSum[32] ? '1 : accSum[31:0];
        if (pulsosReg != '1) begin
          pulsosReg <= pulsosReg + 32'd1;
        end
        accChanged <= 1'b1;
      end
    end
  end

  assign shifted = {sr[30:0], 1'b0};
  assign kInc    = k + 5'd1;

  // Next-state logic. SHIFT looks at the value it is about to store, so the
  // normalised result is ready as soon as the leading one lands on bit 25.
  always_comb begin
    stateNext     = state;
    srNext        = sr;
    kNext         = k;
    pendNext      = pend;
    resultadoNext = resultado;
    despNext      = desp;
    nuevoNext     = 1'b0;

    case (state)
      IDLE: begin
        if (accChanged || pend) begin
          srNext    = acc;
          kNext     = '0;
          pendNext  = 1'b0;
          stateNext = LOAD;
        end
      end
      LOAD: begin
        if (accChanged) pendNext = 1'b1;
        if (sr == '0) begin
          resultadoNext = 16'h0000;
          stateNext     = DONE;
        end else if (|sr[31:26]) begin
          resultadoNext = 16'h7BFF;
          stateNext     = DONE;
        end else if (sr[25]) begin
          resultadoNext = packHalf(sr, k);
          stateNext     = DONE;
        end else begin
          stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (accChanged) pendNext = 1'b1;
        srNext = shifted;
        kNext  = kInc;
        if (shifted[25]) begin
          resultadoNext = packHalf(shifted, kInc);
          stateNext     = DONE;
        end
      end
      DONE: begin
        if (accChanged) pendNext = 1'b1;
        despNext  = resultado;
        nuevoNext = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if (bus.clear) begin
      stateNext = IDLE;
      pendNext  = 1'b0;
      despNext  = desp;
      nuevoNext = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      k         <= '0;
      pend      <= 1'b0;
      resultado <= '0;
      desp      <= '0;
      nuevoReg  <= 1'b0;
    end else begin
      state     <= stateNext;
      sr        <= srNext;
      k         <= kNext;
      pend      <= pendNext;
      resultado <= resultadoNext;
      desp      <= despNext;
      nuevoReg  <= nuevoNext;
    end
  end

  assign bus.desplazamientof = desp;
  assign bus.nuevo           = nuevoReg;
  assign bus.pulsos          = pulsosReg;
  assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_odometro_hall.sv
// Directed bench for odometro_hall: four instances with different debounce
// and circumference settings, a vector table plus multi-cycle corner sequences.
module tb_odometro_hall;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  odometro_hall_if busA ();
  odometro_hall_if busB ();
  odometro_hall_if busC ();
  odometro_hall_if busD ();

  odometro_hall #(.DEBOUNCE_CYCLES(4), .CIRC_Q10(1024))     dutA (.clock(clock), .reset(reset), .bus(busA));
  odometro_hall #(.DEBOUNCE_CYCLES(4), .CIRC_Q10(2130))     dutB (.clock(clock), .reset(reset), .bus(busB));
  odometro_hall #(.DEBOUNCE_CYCLES(4), .CIRC_Q10(33554432)) dutC (.clock(clock), .reset(reset), .bus(busC));
  odometro_hall #(.DEBOUNCE_CYCLES(1), .CIRC_Q10(1024))     dutD (.clock(clock), .reset(reset), .bus(busD));

  typedef struct {
    int          sel;
    int          hiCycles;
    logic [31:0] expPulsos;
    logic [15:0] expDesp;
    int          expStrobes;
    int          expLatency;
  } VectorType;

  VectorType vectors[11];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setSensor(input int sel, input logic v);
    case (sel)
      0:       busA.sensor = v;
      1:       busB.sensor = v;
      2:       busC.sensor = v;
      default: busD.sensor = v;
    endcase
  endtask

  task automatic sampleBus(input int sel, output logic [31:0] p, output logic [15:0] d,
                           output logic n, output logic b);
    case (sel)
      0:       begin p = busA.pulsos; d = busA.desplazamientof; n = busA.nuevo; b = busA.busy; end
      1:       begin p = busB.pulsos; d = busB.desplazamientof; n = busB.nuevo; b = busB.busy; end
      2:       begin p = busC.pulsos; d = busC.desplazamientof; n = busC.nuevo; b = busC.busy; end
      default: begin p = busD.pulsos; d = busD.desplazamientof; n = busD.nuevo; b = busD.busy; end
    endcase
  endtask

  // One 60-cycle window: sensor high for hiCycles, then low long enough to re-arm.
  task automatic applyStimulus(input VectorType v, output logic [31:0] pul, output logic [15:0] desp,
                               output int strobes, output int latency);
    logic [31:0] prevP;
    logic        n, b;
    int          accCycle;
    strobes  = 0;
    latency  = -1;
    accCycle = -1;
    sampleBus(v.sel, prevP, desp, n, b);
    pul = prevP;
    for (int i = 0; i < 60; i++) begin
      setSensor(v.sel, i < v.hiCycles);
      @(posedge clock);
      #1;
      sampleBus(v.sel, pul, desp, n, b);
      if (pul != prevP && accCycle < 0) accCycle = i;
      prevP = pul;
      if (n) begin
        strobes++;
        if (latency < 0 && accCycle >= 0) latency = i - accCycle;
      end
    end
    setSensor(v.sel, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] p, prevP;
    logic [15:0] d;
    logic        n, b;
    int          strobes, latency, accIter;
    logic [15:0] firstVal, lastVal;
    logic        busyAtSecond, busyBefore;
    logic [31:0] pulsosBefore;

    vectors[0]  = '{0, 1,  32'd0, 16'h0000, 0, 0};
    vectors[1]  = '{0, 2,  32'd0, 16'h0000, 0, 0};
    vectors[2]  = '{0, 3,  32'd0, 16'h0000, 0, 0};
    vectors[3]  = '{0, 4,  32'd1, 16'h3C00, 1, 18};
    vectors[4]  = '{0, 10, 32'd2, 16'h4000, 1, 17};
    vectors[5]  = '{1, 8,  32'd1, 16'h4029, 1, 17};
    vectors[6]  = '{1, 8,  32'd2, 16'h4429, 1, 16};
    vectors[7]  = '{1, 8,  32'd3, 16'h463D, 1, 16};
    vectors[8]  = '{2, 8,  32'd1, 16'h7800, 1, 3};
    vectors[9]  = '{2, 8,  32'd2, 16'h7BFF, 1, 3};
    vectors[10] = '{2, 8,  32'd3, 16'h7BFF, 1, 3};

    reset = 1'b1;
    busA.sensor = 1'b0; busB.sensor = 1'b0; busC.sensor = 1'b0; busD.sensor = 1'b0;
    busA.clear  = 1'b0; busB.clear  = 1'b0; busC.clear  = 1'b0; busD.clear  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset desp", 32'(busA.desplazamientof), 32'h0);
    checkOutput("reset nuevo", 32'(busA.nuevo), 32'h0);
    checkOutput("reset pulsos", busA.pulsos, 32'h0);
    checkOutput("reset busy", 32'(busA.busy), 32'h0);
    checkOutput("reset pulsosD", busD.pulsos, 32'h0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vectors[i], p, d, strobes, latency);
      checkOutput($sformatf("v%0d pulsos", i), p, vectors[i].expPulsos);
      checkOutput($sformatf("v%0d desp", i), 32'(d), 32'(vectors[i].expDesp));
      checkOutput($sformatf("v%0d strobes", i), 32'(strobes), 32'(vectors[i].expStrobes));
      if (vectors[i].expStrobes > 0)
        checkOutput($sformatf("v%0d latency", i), 32'(latency), 32'(vectors[i].expLatency));
    end

    // Second pulse lands while the first conversion is still shifting.
    strobes = 0; firstVal = 16'hFFFF; lastVal = 16'hFFFF; busyAtSecond = 1'b0;
    prevP = busD.pulsos;
    for (int i = 0; i < 80; i++) begin
      busD.sensor = (i < 3) || (i >= 6 && i < 9);
      @(posedge clock);
      #1;
      if (busD.pulsos != prevP && busD.pulsos == 32'd2) busyAtSecond = busD.busy;
      prevP = busD.pulsos;
      if (busD.nuevo) begin
        strobes++;
        if (strobes == 1) firstVal = busD.desplazamientof;
        lastVal = busD.desplazamientof;
      end
    end
    busD.sensor = 1'b0;
    checkOutput("pend pulsos", busD.pulsos, 32'd2);
    checkOutput("pend busyAtSecond", 32'(busyAtSecond), 32'd1);
    checkOutput("pend strobes", 32'(strobes), 32'd2);
    checkOutput("pend first", 32'(firstVal), 32'h3C00);
    checkOutput("pend final", 32'(lastVal), 32'h4000);

    // Clear mid-SHIFT, coinciding with a debounced pulse on the same edge.
    strobes = 0; firstVal = 16'hFFFF; latency = -1; accIter = -1;
    busyBefore = 1'b0; pulsosBefore = '0;
    for (int i = 0; i < 60; i++) begin
      busB.sensor = (i < 6) || (i >= 12 && i < 19);
      busB.clear  = (i == 18);
      @(posedge clock);
      #1;
      if (i == 17) begin
        busyBefore   = busB.busy;
        pulsosBefore = busB.pulsos;
      end
      if (i == 18) accIter = i;
      if (busB.nuevo && i > 18) begin
        strobes++;
        if (strobes == 1) begin
          firstVal = busB.desplazamientof;
          latency  = i - accIter;
        end
      end
    end
    busB.sensor = 1'b0;
    busB.clear  = 1'b0;
    checkOutput("clear pulsosBefore", pulsosBefore, 32'd4);
    checkOutput("clear busyBefore", 32'(busyBefore), 32'd1);
    checkOutput("clear pulsos", busB.pulsos, 32'd0);
    checkOutput("clear strobes", 32'(strobes), 32'd1);
    checkOutput("clear value", 32'(firstVal), 32'h0000);
    checkOutput("clear latency", 32'(latency), 32'd3);

    // Reset in the middle of a conversion on instance A.
    busyBefore = 1'b0;
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      busA.sensor = (i < 6);
      reset = (i == 9);
      @(posedge clock);
      #1;
      if (i == 8) busyBefore = busA.busy;
      if (i == 9) begin
        checkOutput("rst desp", 32'(busA.desplazamientof), 32'h0);
        checkOutput("rst nuevo", 32'(busA.nuevo), 32'h0);
        checkOutput("rst pulsos", busA.pulsos, 32'h0);
        checkOutput("rst busy", 32'(busA.busy), 32'h0);
      end
      if (i >= 9 && busA.nuevo) strobes++;
    end
    reset = 1'b0;
    busA.sensor = 1'b0;
    checkOutput("rst busyBefore", 32'(busyBefore), 32'd1);
    checkOutput("rst strobesAfter", 32'(strobes), 32'd0);
    checkOutput("rst pulsosAfter", busA.pulsos, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
